// File: rtl/tea_pkg.sv
// Shared TEA types and constants for the round scheduler and its mix function.
package tea_pkg;

    localparam logic [31:0] TEA_DELTA     = 32'h9E3779B9;
    localparam logic [31:0] TEA_DEC_SUM32 = 32'hC6EF3720;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PH_A = 3'd1,
        ST_PH_B = 3'd2,
        ST_PH_C = 3'd3,
        ST_RESP = 3'd4
    } tea_state_e;

    typedef struct packed {
        logic [31:0] k0;
        logic [31:0] k1;
        logic [31:0] k2;
        logic [31:0] k3;
    } tea_key_t;

    typedef struct packed {
        logic [31:0] v0;
        logic [31:0] v1;
    } tea_block_t;

    // Starting sum for decryption: delta * rounds, modulo 2^32.
    function automatic logic [31:0] tea_dec_sum(input logic [31:0] delta, input int unsigned rounds);
        logic [63:0] prod;
        prod = 64'(delta) * 64'(rounds);
        return prod[31:0];
    endfunction

endpackage

// File: rtl/tea_mix.sv
// TEA round function F(x,s,ka,kb) = ((x<<4)+ka) ^ (x+s) ^ ((x>>5)+kb), purely combinational.
module tea_mix (
    input  logic [31:0] x,
    input  logic [31:0] s,
    input  logic [31:0] ka,
    input  logic [31:0] kb,
    output logic [31:0] f_c
);

    always_comb begin
        f_c = ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    end

endmodule

// File: rtl/tea_round_scheduler.sv
// Two-port round-robin scheduler around one iterative TEA engine (3 cycles per round).
// Optional per-port completion counters are built when TEA_SCHED_STATS_EN is defined.
module tea_round_scheduler
    import tea_pkg::*;
#(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = TEA_DELTA
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s0_valid,
    output logic          s0_ready,
    input  logic          s0_decrypt,
    input  logic [63:0]   s0_v,
    input  logic [127:0]  s0_k,
    output logic          r0_valid,
    input  logic          r0_ready,
    output logic [63:0]   r0_v,
    input  logic          s1_valid,
    output logic          s1_ready,
    input  logic          s1_decrypt,
    input  logic [63:0]   s1_v,
    input  logic [127:0]  s1_k,
    output logic          r1_valid,
    input  logic          r1_ready,
    output logic [63:0]   r1_v,
    output logic          busy,
    output logic          owner
`ifdef TEA_SCHED_STATS_EN
    ,
    output logic [15:0]   ops0_count,
    output logic [15:0]   ops1_count
`endif
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);
    localparam logic [31:0] DEC_SUM = tea_dec_sum(DELTA, ROUNDS);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_PH_A = ST_PH_A;
    localparam logic [2:0] S_PH_B = ST_PH_B;
    localparam logic [2:0] S_PH_C = ST_PH_C;
    localparam logic [2:0] S_RESP = ST_RESP;

    logic [2:0]       state, state_nxt;
    tea_block_t       blk, blk_nxt;
    tea_key_t         key, key_nxt;
    logic             dec, dec_nxt;
    logic [31:0]      sum, sum_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             owner_nxt;

    logic             any_req;
    logic             grant;
    logic             resp_done;
    logic             use_hi;
    logic [31:0]      mix_x, mix_ka, mix_kb, mix_f;

    // On a tie the port that did not own the last job wins.
    always_comb begin
        any_req = s0_valid | s1_valid;
        grant   = (s0_valid && s1_valid) ? ~owner : s1_valid;
    end

    assign s0_ready  = (state == S_IDLE) && any_req && !grant;
    assign s1_ready  = (state == S_IDLE) && any_req && grant;
    assign r0_valid  = (state == S_RESP) && !owner;
    assign r1_valid  = (state == S_RESP) && owner;
    assign r0_v      = blk;
    assign r1_v      = blk;
    assign busy      = (state != S_IDLE);
    assign resp_done = owner ? r1_ready : r0_ready;

    // PH_B always mixes v1 with k0/k1; the other active phase mixes v0 with k2/k3.
    always_comb begin
        use_hi = (state == S_PH_B);
        mix_x  = use_hi ? blk.v1 : blk.v0;
        mix_ka = use_hi ? key.k0 : key.k2;
        mix_kb = use_hi ? key.k1 : key.k3;
    end

    tea_mix u_mix (
        .x   (mix_x),
        .s   (sum),
        .ka  (mix_ka),
        .kb  (mix_kb),
        .f_c (mix_f)
    );

    always_comb begin
        state_nxt = state;
        blk_nxt   = blk;
        key_nxt   = key;
        dec_nxt   = dec;
        sum_nxt   = sum;
        cnt_nxt   = cnt;
        owner_nxt = owner;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    blk_nxt   = grant ? tea_block_t'(s1_v) : tea_block_t'(s0_v);
                    key_nxt   = grant ? tea_key_t'(s1_k) : tea_key_t'(s0_k);
                    dec_nxt   = grant ? s1_decrypt : s0_decrypt;
                    sum_nxt   = (grant ? s1_decrypt : s0_decrypt) ? DEC_SUM : 32'd0;
                    cnt_nxt   = '0;
                    owner_nxt = grant;
                    state_nxt = S_PH_A;
                end
            end
            S_PH_A: begin
                if (dec) begin
                    blk_nxt.v1 = blk.v1 - mix_f;
                end else begin
                    sum_nxt = sum + DELTA;
                end
                state_nxt = S_PH_B;
            end
            S_PH_B: begin
                blk_nxt.v0 = dec ? (blk.v0 - mix_f) : (blk.v0 + mix_f);
                state_nxt  = S_PH_C;
            end
            S_PH_C: begin
                if (dec) begin
                    sum_nxt = sum - DELTA;
                end else begin
                    blk_nxt.v1 = blk.v1 + mix_f;
                end
                cnt_nxt   = cnt + CNT_W'(1);
                state_nxt = (cnt == LAST_ROUND) ? S_RESP : S_PH_A;
            end
            S_RESP: begin
                if (resp_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            blk   <= '0;
            key   <= '0;
            dec   <= 1'b0;
            sum   <= '0;
            cnt   <= '0;
            owner <= 1'b1;
        end else begin
            state <= state_nxt;
            blk   <= blk_nxt;
            key   <= key_nxt;
            dec   <= dec_nxt;
            sum   <= sum_nxt;
            cnt   <= cnt_nxt;
            owner <= owner_nxt;
        end
    end

`ifdef TEA_SCHED_STATS_EN
    // Completed response handshakes per port, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            ops0_count <= '0;
            ops1_count <= '0;
        end else if (state == S_RESP) begin
            if (!owner && r0_ready) begin
                ops0_count <= ops0_count + 16'd1;
            end
            if (owner && r1_ready) begin
                ops1_count <= ops1_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tea_round_scheduler.sv
// Self-checking bench for tea_round_scheduler: vector table, scoreboard queue and corner sequences.
module tb_tea_round_scheduler;

    localparam int unsigned ROUNDS = 32;
    localparam logic [31:0] DELTA  = 32'h9E3779B9;
    localparam int unsigned LAT    = 3 * ROUNDS;

    logic          clk = 1'b0;
    logic          reset;
    logic          s0_valid, s0_ready, s0_decrypt;
    logic [63:0]   s0_v;
    logic [127:0]  s0_k;
    logic          r0_valid, r0_ready;
    logic [63:0]   r0_v;
    logic          s1_valid, s1_ready, s1_decrypt;
    logic [63:0]   s1_v;
    logic [127:0]  s1_k;
    logic          r1_valid, r1_ready;
    logic [63:0]   r1_v;
    logic          busy, owner;
`ifdef TEA_SCHED_STATS_EN
    logic [15:0]   ops0_count, ops1_count;
`endif

    tea_round_scheduler #(.ROUNDS(ROUNDS), .DELTA(DELTA)) dut (
        .clk        (clk),
        .reset      (reset),
        .s0_valid   (s0_valid),
        .s0_ready   (s0_ready),
        .s0_decrypt (s0_decrypt),
        .s0_v       (s0_v),
        .s0_k       (s0_k),
        .r0_valid   (r0_valid),
        .r0_ready   (r0_ready),
        .r0_v       (r0_v),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .s1_decrypt (s1_decrypt),
        .s1_v       (s1_v),
        .s1_k       (s1_k),
        .r1_valid   (r1_valid),
        .r1_ready   (r1_ready),
        .r1_v       (r1_v),
        .busy       (busy),
        .owner      (owner)
`ifdef TEA_SCHED_STATS_EN
        ,
        .ops0_count (ops0_count),
        .ops1_count (ops1_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        bit          dec;
        logic [63:0] v;
        logic [127:0] k;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        int          port;
        logic [63:0] v;
    } sb_t;

    sb_t  q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    int   acc_cyc = 0;
    int   last_port = 1;
    int   done0 = 0;
    int   done1 = 0;

    // Reference TEA, written as the textbook loop.
    function automatic logic [63:0] tea_enc(input logic [63:0] v, input logic [127:0] k);
        logic [31:0] y, z, sum, k0, k1, k2, k3;
        {y, z} = v;
        {k0, k1, k2, k3} = k;
        sum = 32'd0;
        for (int i = 0; i < int'(ROUNDS); i++) begin
            sum = sum + DELTA;
            y = y + ((((z << 4) + k0)) ^ (z + sum) ^ ((z >> 5) + k1));
            z = z + ((((y << 4) + k2)) ^ (y + sum) ^ ((y >> 5) + k3));
        end
        return {y, z};
    endfunction

    function automatic logic [63:0] tea_dec(input logic [63:0] v, input logic [127:0] k);
        logic [31:0] y, z, sum, k0, k1, k2, k3;
        {y, z} = v;
        {k0, k1, k2, k3} = k;
        sum = 32'(DELTA * ROUNDS);
        for (int i = 0; i < int'(ROUNDS); i++) begin
            z = z - ((((y << 4) + k2)) ^ (y + sum) ^ ((y >> 5) + k3));
            y = y - ((((z << 4) + k0)) ^ (z + sum) ^ ((z >> 5) + k1));
            sum = sum - DELTA;
        end
        return {y, z};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic note_timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout (t=%0t)", nm, $time);
    endtask

    function automatic bit s_rdy(input int p);
        return (p == 0) ? s0_ready : s1_ready;
    endfunction

    function automatic bit r_val(input int p);
        return (p == 0) ? r0_valid : r1_valid;
    endfunction

    function automatic logic [63:0] r_data(input int p);
        return (p == 0) ? r0_v : r1_v;
    endfunction

    task automatic drive_req(input int p, input bit dec, input logic [63:0] v,
                             input logic [127:0] k, input bit val);
        if (p == 0) begin
            s0_decrypt = dec; s0_v = v; s0_k = k; s0_valid = val;
        end else begin
            s1_decrypt = dec; s1_v = v; s1_k = k; s1_valid = val;
        end
    endtask

    // Raise a request, wait for its accept edge, and queue the expected result.
    task automatic send(input int p, input bit dec, input logic [63:0] v,
                        input logic [127:0] k, input logic [63:0] e, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        drive_req(p, dec, v, k, 1'b1);
        #1;
        while (!s_rdy(p) && n < 400) begin
            @(negedge clk); #1; n++;
        end
        if (!s_rdy(p)) begin
            note_timeout("accept");
            drive_req(p, dec, v, k, 1'b0);
            return;
        end
        q.push_back('{p, e});
        @(posedge clk); #1;
        acc_cyc = cyc;
        drive_req(p, dec, v, k, 1'b0);
        ok = 1'b1;
    endtask

    task automatic wait_result(input int p, output logic [63:0] res, output bit ok);
        int  n;
        sb_t e;
        n = 0;
        ok = 1'b0;
        res = '0;
        while (!r_val(p) && n < int'(LAT) + 50) begin
            @(negedge clk); #1; n++;
        end
        if (!r_val(p)) begin
            note_timeout("result_valid");
            return;
        end
        ok = 1'b1;
        res = r_data(p);
        chk("latency", 64'(cyc - acc_cyc), 64'(LAT));
        chk("other_r_valid", 64'(r_val(1 - p)), 64'd0);
        chk("owner", 64'(owner), 64'(p));
        if (q.size() == 0) begin
            note_timeout("scoreboard_empty");
        end else begin
            e = q.pop_front();
            chk("result_port", 64'(p), 64'(e.port));
            chk("result_v", res, e.v);
        end
    endtask

    task automatic handshake(input int p);
        if (p == 0) r0_ready = 1'b1; else r1_ready = 1'b1;
        @(posedge clk); #1;
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        if (p == 0) done0++; else done1++;
        chk("busy_after_handshake", 64'(busy), 64'd0);
    endtask

    task automatic run_job(input int p, input bit dec, input logic [63:0] v,
                           input logic [127:0] k, input logic [63:0] e, output logic [63:0] res);
        bit ok;
        res = '0;
        send(p, dec, v, k, e, ok);
        if (!ok) return;
        wait_result(p, res, ok);
        if (ok) handshake(p);
        last_port = p;
    endtask

    initial begin
        logic [63:0]  res, res2, x, held;
        logic [127:0] kk;
        bit           ok;
        int           p, spurious, n;
        logic [127:0] k_a;
        logic [63:0]  v_a;

        reset = 1'b1;
        s0_valid = 0; s0_decrypt = 0; s0_v = '0; s0_k = '0; r0_ready = 0;
        s1_valid = 0; s1_decrypt = 0; s1_v = '0; s1_k = '0; r1_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_owner", 64'(owner), 64'd1);
        chk("rst_r_valid", 64'({r0_valid, r1_valid}), 64'd0);
        chk("rst_r0_v", r0_v, 64'd0);
        chk("rst_r1_v", r1_v, 64'd0);
        chk("rst_s_ready", 64'({s0_ready, s1_ready}), 64'd0);

        k_a = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        v_a = 64'h01234567_89ABCDEF;
        vecs[0] = '{0, 1'b0, 64'd0, 128'd0, 64'h41EA3A0A_94BAA940};
        vecs[1] = '{1, 1'b1, 64'h41EA3A0A_94BAA940, 128'd0, 64'd0};
        vecs[2] = '{0, 1'b0, v_a, k_a, tea_enc(v_a, k_a)};
        vecs[3] = '{1, 1'b0, '1, '1, tea_enc('1, '1)};
        vecs[4] = '{0, 1'b1, v_a, k_a, tea_dec(v_a, k_a)};
        vecs[5] = '{1, 1'b1, 64'hDEADBEEF_CAFEF00D, k_a, tea_dec(64'hDEADBEEF_CAFEF00D, k_a)};
        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].port, vecs[i].dec, vecs[i].v, vecs[i].k, vecs[i].exp, res);
        end

        // Both ports held valid: grants alternate, each result goes to its owner.
        drive_req(0, 1'b0, v_a, k_a, 1'b1);
        drive_req(1, 1'b1, v_a, k_a, 1'b1);
        for (int j = 0; j < 4; j++) begin
            n = 0;
            #1;
            while (!(s0_ready || s1_ready) && n < 400) begin
                @(negedge clk); #1; n++;
            end
            if (!(s0_ready || s1_ready)) begin
                note_timeout("alt_accept");
                break;
            end
            chk("alt_one_ready", 64'(s0_ready & s1_ready), 64'd0);
            p = s1_ready ? 1 : 0;
            chk("alt_grant", 64'(p), 64'(1 - last_port));
            q.push_back('{p, (p == 0) ? tea_enc(v_a, k_a) : tea_dec(v_a, k_a)});
            @(posedge clk); #1;
            acc_cyc = cyc;
            wait_result(p, res, ok);
            if (ok) handshake(p);
            last_port = p;
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;

        // Stalled response: data holds, the waiting port stays blocked, one IDLE gap.
        send(0, 1'b0, 64'h00000001_00000002, k_a, tea_enc(64'h00000001_00000002, k_a), ok);
        drive_req(1, 1'b0, 64'h00000003_00000004, k_a, 1'b1);
        wait_result(0, held, ok);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk); #1;
            chk("hold_r0_v", r0_v, held);
            chk("hold_r0_valid", 64'(r0_valid), 64'd1);
            chk("hold_s1_ready", 64'(s1_ready), 64'd0);
        end
        handshake(0);
        chk("gap_s1_ready", 64'(s1_ready), 64'd1);
        q.push_back('{1, tea_enc(64'h00000003_00000004, k_a)});
        @(posedge clk); #1;
        acc_cyc = cyc;
        s1_valid = 1'b0;
        chk("gap_busy", 64'(busy), 64'd1);
        wait_result(1, res, ok);
        if (ok) handshake(1);
        last_port = 1;

        // Reset 40 cycles into a job aborts it.
        send(0, 1'b0, v_a, k_a, tea_enc(v_a, k_a), ok);
        repeat (40) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete();
        done0 = 0;
        done1 = 0;
        last_port = 1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_owner", 64'(owner), 64'd1);
        chk("abort_r_valid", 64'({r0_valid, r1_valid}), 64'd0);
        chk("abort_r0_v", r0_v, 64'd0);
        spurious = 0;
        for (int j = 0; j < 150; j++) begin
            @(negedge clk); #1;
            if (r0_valid || r1_valid || busy) spurious++;
        end
        chk("abort_no_response", 64'(spurious), 64'd0);
        run_job(0, 1'b0, 64'd0, 128'd0, 64'h41EA3A0A_94BAA940, res);

        // Random round trips through either port.
        for (int j = 0; j < 100; j++) begin
            x  = {$urandom, $urandom};
            kk = {$urandom, $urandom, $urandom, $urandom};
            p  = int'($urandom_range(0, 1));
            run_job(p, 1'b0, x, kk, tea_enc(x, kk), res);
            p  = int'($urandom_range(0, 1));
            run_job(p, 1'b1, res, kk, x, res2);
        end

`ifdef TEA_SCHED_STATS_EN
        chk("ops0_count", 64'(ops0_count), 64'(16'(done0)));
        chk("ops1_count", 64'(ops1_count), 64'(16'(done1)));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tea_round_scheduler.md
Name: tea_round_scheduler

Overview:
- Shares one iterative TEA (Tiny Encryption Algorithm) round engine between two independent requesters (port 0, port 1).
- Arbitrates round-robin and sequences the engine through ROUNDS rounds in either encrypt or decrypt mode.
- Returns the 64-bit result to the requester that owns the job, over a valid/ready handshake.
- Sits between the board-level input/display control and the cipher arithmetic. It replaces ad hoc per-mode sequencing with one reusable scheduled engine.

Parameters:
- ROUNDS, 32: rounds per block. Legal range 1..255.
- DELTA, 32'h9E3779B9: key-schedule constant.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- s0_valid, in, 1: port 0 request valid. Must hold until accepted.
- s0_ready, out, 1: port 0 request accepted this cycle when s0_valid is also high.
- s0_decrypt, in, 1: port 0 mode. 0 = encrypt, 1 = decrypt.
- s0_v, in, 64: port 0 block, {v0[63:32], v1[31:0]}.
- s0_k, in, 128: port 0 key, {k0, k1, k2, k3}, with k0 in the MSBs.
- r0_valid, out, 1: port 0 result valid.
- r0_ready, in, 1: port 0 result consumed.
- r0_v, out, 64: port 0 result, {v0, v1}.
- s1_valid, s1_ready, s1_decrypt, s1_v, s1_k, r1_valid, r1_ready, r1_v: identical meanings for port 1.
- busy, out, 1: high in any state other than IDLE.
- owner, out, 1: index of the port that owns the current or last job.

Behaviour:
- States: IDLE, PH_A, PH_B, PH_C, RESP.
- Reset values: all outputs 0, owner=1 (so port 0 wins the first tie), state=IDLE, working registers, sum and round counter all 0.
- Arbitration (IDLE only):
  - Grant goes to the only valid port.
  - If both ports are valid, grant goes to the port that is not owner.
  - sN_ready is combinational: (state==IDLE) && grant==N. Only one ready is ever high.
- Accept edge: capture v0, v1, the four keys and mode. Set owner=N. Set round counter=0.
  - Encrypt: sum=0.
  - Decrypt: sum=DELTA*ROUNDS mod 2^32 (0xC6EF3720 for ROUNDS=32).
  - Next state is PH_A.
- Let F(x,s,ka,kb) = ((x<<4)+ka) ^ (x+s) ^ ((x>>5)+kb). All arithmetic is 32-bit modulo 2^32 and all shifts are logical.
- Encrypt round:
  - PH_A: sum += DELTA.
  - PH_B: v0 += F(v1,sum,k0,k1).
  - PH_C: v1 += F(v0,sum,k2,k3), using the updated v0.
- Decrypt round:
  - PH_A: v1 -= F(v0,sum,k2,k3).
  - PH_B: v0 -= F(v1,sum,k0,k1).
  - PH_C: sum -= DELTA.
- Full XOR of F is taken before the add or subtract.
- Round sequencing: PH_C increments the round counter. If counter==ROUNDS-1, next state is RESP; otherwise next state is PH_A.
- Latency: rOwner_valid rises exactly 3*ROUNDS cycles after the accept edge (96 cycles at the default).
- RESP:
  - rN_valid=1 for the owner only. rN_v={v0,v1} is held stable.
  - Stays in RESP until rN_ready. The handshake cycle moves to IDLE.
  - The non-owner's r_ready is ignored.
- Back-to-back: no request is accepted in the response-handshake cycle. Minimum one IDLE cycle between jobs.
- A requester that is valid but not granted keeps waiting. Its inputs may not change while valid.
- Reset mid-job: the job is aborted, no response is produced, and all reset values apply on the next edge.

Optional Feature:
- Macro: TEA_SCHED_STATS_EN.
- When defined:
  - Adds output ports ops0_count[15:0] and ops1_count[15:0]. Both reset to 0.
  - A counter increments on each completed response handshake of its port.
  - Counters wrap 0xFFFF to 0x0000.
- When undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package tea_pkg holds:
  - TEA_DELTA constant.
  - TEA_DEC_SUM32 constant (0xC6EF3720).
  - State enum typedef.
  - Packed structs for the 128-bit key and the 64-bit block.
  - A function computing DELTA*ROUNDS.
- One combinational sub-module, tea_mix, computes F(x,s,ka,kb). It is instanced once and its inputs are muxed by phase and mode.

Test Plan:
- Encrypt on port 0, v=0, k=0 -> r0_valid after 96 cycles, r0_v=64'h41EA3A0A_94BAA940, busy low after handshake.
- Decrypt on port 1, v=64'h41EA3A0A_94BAA940, k=0 -> r1_v=0. Also round-trip 100 random v/k pairs: decrypt(encrypt(x))==x.
- s0_valid and s1_valid held high continuously -> grants alternate 0,1,0,1. owner toggles each job. Each r_valid goes only to its owner.
- Hold r0_ready low for 20 cycles in RESP -> r0_v stable, s1_ready stays 0, and s1 is accepted only after the r0 handshake plus one IDLE cycle.
- Assert reset at cycle 40 of a job -> no r0_valid, all outputs 0, and a new request is accepted normally with correct result.
- With TEA_SCHED_STATS_EN: run 65537 port-0 jobs (force ROUNDS=1) -> ops0_count=1 and ops1_count=0.
